// File: rtl/pw_pack_pkg.sv
// rtl/pw_pack_pkg.sv - shared tags, state encoding and END-word layout for fe_capture_pack
//
// Purpose: constants shared by the capture packer and its delta timer.
// Ports:   none (package).
package pw_pack_pkg;

  // 2-bit tag carried in O_data[17:16]
  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_TIME = 2'b01;
  localparam logic [1:0] TAG_TRIG = 2'b10;
  localparam logic [1:0] TAG_END  = 2'b11;

  // Capture sequence state encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_END     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // END payload layout: {full_flag, drop_cnt[14:0]}
  localparam int END_FULL_BIT = 15;
  localparam int END_DROP_LSB = 0;

  // Timestamp saturation value
  localparam logic [15:0] TS_MAX = 16'hFFFF;

endpackage

// File: rtl/pw_delta_timer.sv
// rtl/pw_delta_timer.sv - saturating delta timestamp counter for fe_capture_pack
//
// Purpose: 16-bit ts counter; loads 1 when a word is generated, otherwise
//          increments while capturing and saturates at 16'hFFFF.
//          Only present in builds with PW_TIMESTAMP_EN defined.
// Ports:
//   clk_i    in   front-end clock
//   rst_ni   in   asynchronous active-low reset
//   run_i    in   count enable (CAPTURE state)
//   load_i   in   a word is generated this cycle; ts restarts at 1
//   ts_o     out  current timestamp
//   gt255_o  out  ts no longer fits the 8-bit DATA delta field
//   sat_o    out  ts has reached 16'hFFFF
`ifdef PW_TIMESTAMP_EN
module pw_delta_timer
  import pw_pack_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        load_i,
  output logic [15:0] ts_o,
  output logic        gt255_o,
  output logic        sat_o
);

  logic [15:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (load_i) begin
      ts_d = 16'd1;
    end else if (run_i && (ts_q != TS_MAX)) begin
      ts_d = ts_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign ts_o    = ts_q;
  assign gt255_o = |ts_q[15:8];
  assign sat_o   = (ts_q == TS_MAX);

endmodule
`endif

// File: rtl/fe_capture_pack.sv
// rtl/fe_capture_pack.sv - packs front-end bytes and trigger into tagged 18-bit capture FIFO words
//
// Purpose: IDLE -> ARMED -> CAPTURE -> END -> DONE capture sequencer that
//          emits TRIG/TIME/DATA/END words to the capture FIFO write port.
// Build option: PW_TIMESTAMP_EN enables the delta timestamp (TIME words,
//          DATA delta field, >255 hold path). Without it the delta field is 0.
// Ports:
//   fe_clk, reset_n        clock, asynchronous active-low reset
//   I_arm                  level; rising edge arms, low aborts / returns to IDLE
//   I_trigger              single-cycle trigger pulse
//   I_capture_len          DATA words per capture (0 = unlimited)
//   I_data, I_data_valid   front-end byte and strobe
//   I_fifo_full            FIFO almost-full threshold
//   O_data, O_wr           registered FIFO word {tag, payload} and write strobe
//   O_capturing            in CAPTURE
//   O_capture_done         in DONE
//   O_dropped              sticky: a byte was dropped this capture
module fe_capture_pack
  import pw_pack_pkg::*;
#(
  parameter int pLEN_WIDTH  = 20,
  parameter int pDROP_WIDTH = 15
) (
  input  logic                  fe_clk,
  input  logic                  reset_n,
  input  logic                  I_arm,
  input  logic                  I_trigger,
  input  logic [pLEN_WIDTH-1:0] I_capture_len,
  input  logic [7:0]            I_data,
  input  logic                  I_data_valid,
  input  logic                  I_fifo_full,
  output logic [17:0]           O_data,
  output logic                  O_wr,
  output logic                  O_capturing,
  output logic                  O_capture_done,
  output logic                  O_dropped
);

  localparam int DW1 = pDROP_WIDTH + 1;

`ifdef PW_TIMESTAMP_EN
  // A held byte always follows a word generated the previous cycle, so ts is 1.
  localparam logic [7:0] HOLD_DELTA = 8'h01;
  logic [15:0] ts;
  logic        ts_gt, ts_sat;
`else
  localparam logic [7:0] HOLD_DELTA = 8'h00;
`endif

  state_e                 state_q, state_d;
  logic                   arm_q;
  logic                   hold_v_q, hold_v_d;
  logic [7:0]             hold_q, hold_d;
  logic [pLEN_WIDTH-1:0]  data_cnt_q, data_cnt_d;
  logic [pDROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                   full_flag_q, full_flag_d;
  logic                   dropped_q, dropped_d;
  logic [17:0]            data_q, data_d;
  logic                   wr_q, wr_d;
  logic                   capturing_q, done_q;

  logic                   arm_rise, go_end, clr_cnt;
  logic [1:0]             drop_inc;
  logic [pDROP_WIDTH-1:0] drop_base;
  logic [DW1-1:0]         drop_sum;
  logic [15:0]            end_payload;

  assign arm_rise = I_arm & ~arm_q;

`ifdef PW_TIMESTAMP_EN
  pw_delta_timer u_timer (
    .clk_i   (fe_clk),
    .rst_ni  (reset_n),
    .run_i   (state_q == ST_CAPTURE),
    .load_i  (wr_d),
    .ts_o    (ts),
    .gt255_o (ts_gt),
    .sat_o   (ts_sat)
  );
`endif

  always_comb begin
    state_d     = state_q;
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;
    data_cnt_d  = data_cnt_q;
    full_flag_d = full_flag_q;
    dropped_d   = dropped_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    drop_inc    = 2'd0;
    go_end      = 1'b0;
    clr_cnt     = 1'b0;
    end_payload = '0;

    case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          state_d     = ST_ARMED;
          clr_cnt     = 1'b1;
          data_cnt_d  = '0;
          full_flag_d = 1'b0;
          dropped_d   = 1'b0;
          hold_v_d    = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!I_arm) begin
          state_d = ST_IDLE;
        end else if (I_trigger) begin
          state_d = ST_CAPTURE;
          wr_d    = 1'b1;
          data_d  = {TAG_TRIG, 16'h0000};
          if (I_data_valid) begin
            hold_v_d = 1'b1;
            hold_d   = I_data;
          end
        end
      end
      ST_CAPTURE: begin
        if (I_fifo_full) begin
          // Nothing more is written; the pending hold byte and this byte are lost.
          full_flag_d = 1'b1;
          go_end      = 1'b1;
          hold_v_d    = 1'b0;
          drop_inc    = {1'b0, hold_v_q} + {1'b0, I_data_valid};
        end else begin
          if (hold_v_q) begin
            wr_d       = 1'b1;
            data_d     = {TAG_DATA, HOLD_DELTA, hold_q};
            hold_v_d   = 1'b0;
            data_cnt_d = data_cnt_q + pLEN_WIDTH'(1);
            if (I_data_valid) drop_inc = 2'd1;
          end else if (I_data_valid) begin
`ifdef PW_TIMESTAMP_EN
            if (ts_gt) begin
              // Delta does not fit: emit absolute ts now, the byte follows next cycle.
              wr_d     = 1'b1;
              data_d   = {TAG_TIME, ts};
              hold_v_d = 1'b1;
              hold_d   = I_data;
            end else begin
              wr_d       = 1'b1;
              data_d     = {TAG_DATA, ts[7:0], I_data};
              data_cnt_d = data_cnt_q + pLEN_WIDTH'(1);
            end
`else
            wr_d       = 1'b1;
            data_d     = {TAG_DATA, 8'h00, I_data};
            data_cnt_d = data_cnt_q + pLEN_WIDTH'(1);
`endif
          end
`ifdef PW_TIMESTAMP_EN
          else if (ts_sat) begin
            wr_d   = 1'b1;
            data_d = {TAG_TIME, TS_MAX};
          end
`endif
          if (!I_arm || ((I_capture_len != '0) && (data_cnt_d == I_capture_len))) begin
            go_end = 1'b1;
          end
        end
        if (go_end) begin
          state_d = ST_END;
          if (hold_v_d) begin
            hold_v_d = 1'b0;
            drop_inc = drop_inc + 2'd1;
          end
        end
      end
      ST_END: begin
        // END is written regardless of I_fifo_full; the threshold leaves room for it.
        state_d  = ST_DONE;
        wr_d     = 1'b1;
        hold_v_d = 1'b0;
        if (I_data_valid) drop_inc = 2'd1;
      end
      ST_DONE: begin
        if (!I_arm) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drop_base  = clr_cnt ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, drop_base} + DW1'(drop_inc);
    drop_cnt_d = drop_sum[pDROP_WIDTH] ? '1 : drop_sum[pDROP_WIDTH-1:0];
    if (drop_inc != 2'd0) dropped_d = 1'b1;

    // END payload reports every byte lost up to and including the END cycle.
    if (state_q == ST_END) begin
      end_payload[END_FULL_BIT]                           = full_flag_q;
      end_payload[END_DROP_LSB +: pDROP_WIDTH]            = drop_cnt_d;
      data_d                                              = {TAG_END, end_payload};
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b1;  // an already-high I_arm after reset is not an edge
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      data_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      full_flag_q <= 1'b0;
      dropped_q   <= 1'b0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= I_arm;
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      data_cnt_q  <= data_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      full_flag_q <= full_flag_d;
      dropped_q   <= dropped_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      capturing_q <= (state_d == ST_CAPTURE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign O_data         = data_q;
  assign O_wr           = wr_q;
  assign O_capturing    = capturing_q;
  assign O_capture_done = done_q;
  assign O_dropped      = dropped_q;

endmodule

// File: tb/tb_fe_capture_pack.sv
// tb/tb_fe_capture_pack.sv - scoreboard testbench for fe_capture_pack
module tb_fe_capture_pack;

`ifdef PW_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        fe_clk = 1'b0;
  logic        reset_n;
  logic        I_arm;
  logic        I_trigger;
  logic [19:0] I_capture_len;
  logic [7:0]  I_data;
  logic        I_data_valid;
  logic        I_fifo_full;
  logic [17:0] O_data;
  logic        O_wr;
  logic        O_capturing;
  logic        O_capture_done;
  logic        O_dropped;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  always #5 fe_clk = ~fe_clk;

  fe_capture_pack #(.pLEN_WIDTH(20), .pDROP_WIDTH(15)) dut (
    .fe_clk         (fe_clk),
    .reset_n        (reset_n),
    .I_arm          (I_arm),
    .I_trigger      (I_trigger),
    .I_capture_len  (I_capture_len),
    .I_data         (I_data),
    .I_data_valid   (I_data_valid),
    .I_fifo_full    (I_fifo_full),
    .O_data         (O_data),
    .O_wr           (O_wr),
    .O_capturing    (O_capturing),
    .O_capture_done (O_capture_done),
    .O_dropped      (O_dropped)
  );

  // Monitor: every FIFO write is matched against the next expected word.
  initial begin
    forever begin
      @(negedge fe_clk);
      if (O_wr) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fifo_word unexpected write got=%h need=none", O_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (O_data !== mon_exp) begin
            n_fail++;
            $display("FAIL fifo_word got=%h need=%h", O_data, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge fe_clk);
  endtask

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] need);
    n_checks++;
    if (got !== need) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", name, got, need);
    end
  endtask

  task automatic arm_up();
    I_arm = 1'b0;
    tick();
    I_arm = 1'b1;
    tick();
  endtask

  task automatic trigger(input logic bv, input logic [7:0] b);
    exp_q.push_back(18'h20000);
    I_trigger    = 1'b1;
    I_data_valid = bv;
    I_data       = b;
    tick();
    I_trigger    = 1'b0;
    I_data_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    I_data       = b;
    I_data_valid = 1'b1;
    tick();
    I_data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending=%0d need=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0; I_arm = 1'b0; I_trigger = 1'b0; I_capture_len = '0;
    I_data = 8'h00; I_data_valid = 1'b0; I_fifo_full = 1'b0;
    tick(2);
    check("rst_data", O_data, 18'h0);
    check("rst_wr", O_wr, 18'h0);
    check("rst_capturing", O_capturing, 18'h0);
    check("rst_done", O_capture_done, 18'h0);
    check("rst_dropped", O_dropped, 18'h0);
    reset_n = 1'b1;
    tick(2);

    // Length-limited capture: len=2, bytes at T+1 and T+3.
    I_capture_len = 20'd2;
    arm_up();
    trigger(1'b0, 8'h00);
    check("capturing_on", O_capturing, 18'h1);
    exp_q.push_back(TS_EN ? 18'h00111 : 18'h00011);
    send(8'h11);
    tick();
    exp_q.push_back(TS_EN ? 18'h00222 : 18'h00022);
    send(8'h22);
    exp_q.push_back(18'h30000);
    tick();
    check("done_at_end", O_capture_done, 18'h1);
    check("capturing_off", O_capturing, 18'h0);
    drain("len_capture");
    I_arm = 1'b0;
    tick(3);
    check("done_cleared", O_capture_done, 18'h0);
    I_capture_len = '0;

    // Trigger-cycle byte held, next byte hits the occupied hold and is dropped.
    arm_up();
    trigger(1'b1, 8'h33);
    exp_q.push_back(TS_EN ? 18'h00133 : 18'h00033);
    send(8'h44);
    check("dropped_hold", O_dropped, 18'h1);
    exp_q.push_back(18'h30001);
    I_arm = 1'b0;
    tick(2);
    drain("hold_drop");
    tick(2);

    // FIFO full: held byte discarded, full-cycle byte and END-cycle byte dropped.
    arm_up();
    check("dropped_clear", O_dropped, 18'h0);
    trigger(1'b1, 8'h55);
    I_fifo_full  = 1'b1;
    I_data       = 8'h66;
    I_data_valid = 1'b1;
    exp_q.push_back(18'h38003);
    tick();
    I_data = 8'h77;
    tick();
    I_data_valid = 1'b0;
    check("full_dropped", O_dropped, 18'h1);
    check("full_done", O_capture_done, 18'h1);
    I_fifo_full = 1'b0;
    drain("fifo_full");
    I_arm = 1'b0;
    tick(3);

`ifdef PW_TIMESTAMP_EN
    // Byte 300 cycles after TRIG, followed immediately by a second byte.
    arm_up();
    trigger(1'b0, 8'h00);
    tick(299);
    exp_q.push_back(18'h1012C);
    exp_q.push_back(18'h001AB);
    send(8'hAB);
    send(8'hCD);
    check("dropped_gap", O_dropped, 18'h1);
    exp_q.push_back(18'h30001);
    I_arm = 1'b0;
    tick(2);
    drain("delta_overflow");
    tick(2);

    // Idle timeout: TIME FFFF once ts saturates, then ts restarts at 1.
    arm_up();
    trigger(1'b0, 8'h00);
    exp_q.push_back(18'h1FFFF);
    tick(65535);
    tick(2);
    exp_q.push_back(18'h0035A);
    send(8'h5A);
    exp_q.push_back(18'h30000);
    I_arm = 1'b0;
    tick(2);
    drain("idle_timeout");
    tick(2);
`endif

    // Asynchronous reset mid-capture, I_arm held high afterwards.
    arm_up();
    trigger(1'b0, 8'h00);
    exp_q.push_back(TS_EN ? 18'h00199 : 18'h00099);
    send(8'h99);
    check("wr_before_reset", O_wr, 18'h1);
    check("capt_before_reset", O_capturing, 18'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", O_data, 18'h0);
    check("async_rst_wr", O_wr, 18'h0);
    check("async_rst_capturing", O_capturing, 18'h0);
    check("async_rst_done", O_capture_done, 18'h0);
    check("async_rst_dropped", O_dropped, 18'h0);
    tick(3);
    reset_n = 1'b1;
    tick(4);
    I_trigger = 1'b1;
    tick();
    I_trigger = 1'b0;
    tick(3);
    check("no_rearm_capturing", O_capturing, 18'h0);
    check("no_rearm_wr", O_wr, 18'h0);
    check("no_rearm_done", O_capture_done, 18'h0);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_capture_pack.md
# fe_capture_pack

Upstream neighbour of the capture FIFO, in the `fe_clk` domain. It turns the front-end byte stream and trigger into tagged 18-bit FIFO words (TRIG, TIME, DATA, END) and drives the FIFO write port. It carries delta timestamps, honours the FIFO's almost-full threshold and ends each capture with a status word. A capture runs IDLE → ARMED → CAPTURE → END → DONE.

## Interface
Parameters:
- pLEN_WIDTH, 20, width of capture-length and data-word counters
- pDROP_WIDTH, 15, width of saturating drop counter (fits END payload)

Ports:
- fe_clk  in  1  front-end clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- I_arm  in  1  level; rising edge arms, low aborts/returns to IDLE
- I_trigger  in  1  single-cycle trigger pulse
- I_capture_len  in  pLEN_WIDTH  DATA words per capture; 0 = unlimited
- I_data  in  8  front-end byte
- I_data_valid  in  1  byte strobe
- I_fifo_full  in  1  FIFO almost-full threshold (write side)
- O_data  out  18  FIFO word {tag[1:0], payload[15:0]}
- O_wr  out  1  FIFO write strobe
- O_capturing  out  1  high in CAPTURE
- O_capture_done  out  1  high in DONE
- O_dropped  out  1  sticky: at least one byte dropped this capture

## Operation
- Tags:
  - 00 DATA {delta[7:0], byte}
  - 01 TIME {ts[15:0]}
  - 10 TRIG {16'h0000}
  - 11 END {full_flag, drop_cnt[14:0]}
- Generation limit: at most one word generated per cycle.
- Timestamp counter:
  - ts is 16 bits and increments every CAPTURE cycle, saturating at 16'hFFFF.
  - ts loads 1 in the cycle any word is generated.
- IDLE: rising edge of I_arm → ARMED; clear data_cnt, drop_cnt, full_flag, O_dropped.
- ARMED:
  - I_arm low → IDLE, no words.
  - I_trigger → CAPTURE; generate TRIG.
  - A byte valid in the trigger cycle goes to the hold register.
- CAPTURE byte with ts ≤ 255: generate DATA with delta=ts[7:0].
- CAPTURE byte with ts > 255:
  - Generate TIME with payload ts; place the byte in the 1-entry hold register.
  - Next cycle, generate DATA from hold with delta 1.
- Hold register occupied: a new byte is dropped; drop_cnt+1 (saturating at 0x7FFF); O_dropped←1.
- ts reaching 16'hFFFF with no byte: generate TIME 16'hFFFF.
- data_cnt increments per DATA generated. When data_cnt equals a nonzero I_capture_len → END.
- I_fifo_full high in CAPTURE:
  - Set full_flag, generate nothing further, go to END.
  - Bytes are dropped and counted; a pending hold byte is discarded and counted.
- I_arm low in CAPTURE: go to END; a pending hold byte is discarded and counted.
- END:
  - Generate the END word, written even if I_fifo_full; the FIFO threshold reserves headroom.
  - Then → DONE.
- DONE: O_capture_done=1; I_arm low → IDLE.
- Simultaneous events:
  - END conditions are evaluated after the cycle's word generation.
  - A hold DATA has priority over TIME saturation.

## Timing
- O_data/O_wr are registered: a word generated in cycle N appears with O_wr=1 in cycle N+1.
- Byte at N (ts ≤ 255) → written N+1. Byte at N (ts > 255) → TIME at N+1, DATA at N+2.
- O_capturing and O_capture_done are registered state decodes.
- Reset values: O_data=0, O_wr=0, O_capturing=0, O_capture_done=0, O_dropped=0; state IDLE.
- reset_n assertion mid-capture clears everything immediately. After release, I_arm already high does not arm; a fresh rising edge is required.

## Configuration
- PW_TIMESTAMP_EN defined: ts, TIME words and hold path behave as above.
- PW_TIMESTAMP_EN undefined:
  - No ts counter, no TIME words.
  - DATA delta field is 8'h00 and every byte is written at N+1.
  - The hold register is used only for the trigger-cycle byte.

## Structure
- Shared package `pw_pack_pkg`: tag constants (TAG_DATA/TIME/TRIG/END), state enum encoding, END payload bit positions.
- Sub-module `pw_delta_timer`: ts counter with load-1, saturation and the >255 compare.

## Test plan
- Capture sequence:
  - Stimulus: len=2, trigger at T, byte 0x11 at T+1, byte 0x22 at T+3.
  - Required writes: 18'h20000, 18'h00111, 18'h00222, 18'h30000; O_capture_done=1 at T+5.
- Delta overflow: byte 0xAB 300 cycles after TRIG → 18'h1012C, then 18'h001AB on the next cycle.
- Idle timeout: no bytes for 70000 cycles → 18'h1FFFF written once ts reaches FFFF; ts restarts at 1.
- Drop: two consecutive bytes after a >255 gap → second byte dropped, O_dropped=1; on arm low, END = 18'h30001.
- FIFO full: I_fifo_full high mid-capture with 3 bytes arriving → no further DATA; END = 18'h38003 written despite full.
- Reset: reset_n low mid-capture → all outputs 0 asynchronously; I_arm held high afterwards does not re-arm.
